// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg: ALU control encodings and the multiply-sequencer state type.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  // cntrl[0] is the adder carry-in, so ADD and SUB differ only in bit 0
  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;
  localparam logic [2:0] ALU_AND    = 3'b100;
  localparam logic [2:0] ALU_OR     = 3'b101;
  localparam logic [2:0] ALU_XOR    = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mseq_state_t;

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ----------------------------------------------------------------------------
// alu: combinational 64-bit ALU with add/sub carry chain and status flags.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       cntrl,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;

  // Subtraction is a + ~b + 1, with the +1 coming from cntrl[0]
  assign w_b_eff = cntrl[0] ? ~b : b;
  assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, cntrl[0]};

  always_comb begin
    result = '0;
    case (cntrl)
      ALU_PASS_B: result = b;
      ALU_ADD:    result = w_sum[WIDTH-1:0];
      ALU_SUB:    result = w_sum[WIDTH-1:0];
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_XOR:    result = a ^ b;
      default:    result = '0;
    endcase
  end

  assign carry_out = w_sum[WIDTH];
  assign overflow  = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
  assign zero      = (result == '0);
  assign negative  = result[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/mult_sequencer.sv
// ----------------------------------------------------------------------------
// mult_sequencer: iterative 64x64 unsigned shift-add multiplier, one ALU add
// per cycle, full 128-bit product after a fixed 64-step run.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mult_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi
);

  localparam logic [6:0] c_last_cnt = 7'(WIDTH - 1);

  mseq_state_t      r_state;
  mseq_state_t      w_next_state;

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mq;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_product_lo;
  logic [WIDTH-1:0] r_product_hi;
  logic [6:0]       r_cnt;

  logic [WIDTH-1:0] w_alu_b;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_next_acc;
  logic [WIDTH-1:0] w_next_mq;
  logic             w_accept;
  logic             w_last_step;
  logic             w_unused_overflow;
  logic             w_unused_zero;
  logic             w_unused_negative;

  assign w_alu_b = r_mq[0] ? r_mcand : '0;

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a         (r_acc),
    .b         (w_alu_b),
    .cntrl     (ALU_ADD),
    .result    (w_sum),
    .carry_out (w_carry),
    .overflow  (w_unused_overflow),
    .zero      (w_unused_zero),
    .negative  (w_unused_negative)
  );

  // {carry, sum, mq} >> 1: the carry becomes the new top bit of acc
  assign w_next_acc = {w_carry, w_sum[WIDTH-1:1]};
  assign w_next_mq  = {w_sum[0], r_mq[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_last_step  = 1'b0;
    ready        = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = RUN;
        end
      end
      RUN: begin
        if (r_cnt == c_last_cnt) begin
          w_last_step  = 1'b1;
          w_next_state = DONE;
        end
      end
      DONE: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc        <= '0;
      r_mq         <= '0;
      r_mcand      <= '0;
      r_cnt        <= '0;
      r_product_lo <= '0;
      r_product_hi <= '0;
    end else begin
      if (w_accept) begin
        r_mcand <= a;
        r_acc   <= '0;
        r_mq    <= b;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_acc <= w_next_acc;
        r_mq  <= w_next_mq;
        r_cnt <= r_cnt + 7'd1;
      end
      // Result registers only move on the step that enters DONE
      if (w_last_step) begin
        r_product_hi <= w_next_acc;
        r_product_lo <= w_next_mq;
      end
    end
  end

  assign product_lo = r_product_lo;
  assign product_hi = r_product_hi;

endmodule

`default_nettype wire

// File: tb/tb_mult_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mult_sequencer: directed self-checking bench for mult_sequencer.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mult_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] a;
  logic [63:0] b;
  logic        ready;
  logic        done;
  logic [63:0] product_lo;
  logic [63:0] product_hi;

  int checks = 0;
  int errors = 0;

  mult_sequencer #(.WIDTH(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .ready      (ready),
    .done       (done),
    .product_lo (product_lo),
    .product_hi (product_hi)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Launch one multiply and wait (bounded) for done; lat = negedges after accept edge
  task automatic do_mul(input logic [63:0] ta, input logic [63:0] tb_v,
                        output logic [63:0] lo, output logic [63:0] hi, output int lat);
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = ~ta; b = ~tb_v;
    lat = -1; lo = '0; hi = '0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k; lo = product_lo; hi = product_hi;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (product_lo !== 64'd0) begin errors++; $display("FAIL reset_lo got %h want 0", product_lo); end
    checks++; if (product_hi !== 64'd0) begin errors++; $display("FAIL reset_hi got %h want 0", product_hi); end
    reset = 1'b0;
  endtask

  task automatic test_products();
    logic [63:0] va [4] = '{64'd3, 64'd0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] vb [4] = '{64'd5, 64'h1234, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] eh [4] = '{64'd0, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE};
    logic [63:0] el [4] = '{64'd15, 64'd0, 64'd0, 64'd1};
    logic [63:0] lo, hi;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_mul(va[i], vb[i], lo, hi, lat);
      checks++; if (lat !== 65) begin errors++; $display("FAIL prod%0d_latency got %0d want 65", i, lat); end
      checks++; if (lo !== el[i]) begin errors++; $display("FAIL prod%0d_lo got %h want %h", i, lo, el[i]); end
      checks++; if (hi !== eh[i]) begin errors++; $display("FAIL prod%0d_hi got %h want %h", i, hi, eh[i]); end
      @(negedge clk);
      checks++; if (ready !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL prod%0d_after ready=%b done=%b want ready=1 done=0", i, ready, done);
      end
      checks++; if (product_lo !== el[i] || product_hi !== eh[i]) begin
        errors++; $display("FAIL prod%0d_hold got %h_%h want %h_%h", i, product_hi, product_lo, eh[i], el[i]);
      end
    end
  endtask

  // Previous result must be FFFF..FFFE_0000..0001 (all-ones square)
  task automatic test_start_ignored();
    logic [63:0] lo, hi;
    int lat;
    bit stable;
    @(negedge clk);
    a = 64'h0000_0001_0000_0001; b = 64'h10; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = 64'hAAAA_AAAA_AAAA_AAAA; b = 64'h5555;
    stable = 1'b1; lat = -1; lo = '0; hi = '0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k; lo = product_lo; hi = product_hi;
        start = 1'b1; a = 64'h9; b = 64'h9;
        break;
      end
      if (product_lo !== 64'd1 || product_hi !== 64'hFFFF_FFFF_FFFF_FFFE || ready !== 1'b0) stable = 1'b0;
      if (k == 1 || k == 40) begin
        start = 1'b1; a = 64'hFFFF_FFFF_0000_0000 + 64'(k); b = 64'h7777;
      end else begin
        start = 1'b0;
      end
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL ign_stable_in_run got %b want 1", stable); end
    checks++; if (lat !== 65) begin errors++; $display("FAIL ign_latency got %0d want 65", lat); end
    checks++; if (lo !== 64'h0000_0010_0000_0010) begin errors++; $display("FAIL ign_lo got %h want 0000001000000010", lo); end
    checks++; if (hi !== 64'd0) begin errors++; $display("FAIL ign_hi got %h want 0", hi); end
    @(negedge clk);
    start = 1'b0;
    checks++; if (ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL ign_after_done ready=%b done=%b want ready=1 done=0", ready, done);
    end
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ign_no_retrigger ready got %b want 1", ready); end
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] lo, hi;
    int lat;
    @(negedge clk);
    a = 64'hDEAD_BEEF_0000_1111; b = 64'hFFFF; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl ready=%b done=%b want ready=1 done=0", ready, done);
    end
    checks++; if (product_lo !== 64'd0 || product_hi !== 64'd0) begin
      errors++; $display("FAIL midrst_products got %h_%h want 0_0", product_hi, product_lo);
    end
    do_mul(64'd7, 64'd6, lo, hi, lat);
    checks++; if (lat !== 65) begin errors++; $display("FAIL midrst_latency got %0d want 65", lat); end
    checks++; if (lo !== 64'd42 || hi !== 64'd0) begin
      errors++; $display("FAIL midrst_7x6 got %h_%h want 0_2a", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int done_at[$];
    int k;
    int d0, d1, d2;
    bit prev_done, dbl, bad;
    @(negedge clk);
    a = 64'h1234; b = 64'h100; start = 1'b1;
    @(posedge clk);
    k = 0; prev_done = 1'b0; dbl = 1'b0; bad = 1'b0;
    while (done_at.size() < 3 && k < 300) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) begin
        if (prev_done) dbl = 1'b1;
        done_at.push_back(k);
        if (product_lo !== 64'h12_3400 || product_hi !== 64'd0) bad = 1'b1;
        if (done_at.size() == 3) start = 1'b0;
      end
      prev_done = (done === 1'b1);
    end
    @(negedge clk);
    if (done === 1'b1) dbl = 1'b1;
    d0 = (done_at.size() > 0) ? done_at[0] : -1;
    d1 = (done_at.size() > 1) ? done_at[1] : -1;
    d2 = (done_at.size() > 2) ? done_at[2] : -1;
    checks++; if (done_at.size() != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", done_at.size()); end
    checks++; if (d0 != 65) begin errors++; $display("FAIL b2b_first got %0d want 65", d0); end
    checks++; if (d1 - d0 != 66) begin errors++; $display("FAIL b2b_gap1 got %0d want 66", d1 - d0); end
    checks++; if (d2 - d1 != 66) begin errors++; $display("FAIL b2b_gap2 got %0d want 66", d2 - d1); end
    checks++; if (dbl !== 1'b0) begin errors++; $display("FAIL b2b_double_done got %b want 0", dbl); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL b2b_products got %b want 0", bad); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_idle ready got %b want 1", ready); end
  endtask

  initial begin
    test_reset();
    test_products();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
